present_decrypt: RTL

PRESENT_DECRYPT -- requirements
Module: present_decrypt

---
 rtl/present_pkg.sv | 31 +++
 rtl/present_decrypt_if.sv | 16 +
 rtl/present_inv_round.sv | 18 +
 rtl/present_decrypt.sv | 115 +++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// present_pkg: PRESENT-80 constants, S-box tables, FSM state type and key-schedule helpers
package present_pkg;
    localparam int SIZE = 64;
    localparam int KEY_SIZE = 80;
    localparam int NUM_ROUNDS = 31;
    localparam logic [63:0] SBOX = 64'hC56B90AD3EF84712;
    localparam logic [63:0] INV_SBOX = 64'h5EF8C12DB463079A;
    typedef enum logic [1:0] {IDLE, KEYEXP, WHITEN, ROUND} fsm_e;
    // nibble 0 of each table sits in the top four bits
    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[60 - 4 * int'(x) +: 4];
    endfunction
    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX[60 - 4 * int'(x) +: 4];
    endfunction
    function automatic logic [KEY_SIZE-1:0] key_fwd(input logic [KEY_SIZE-1:0] k, input logic [4:0] c);
        logic [KEY_SIZE-1:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ c;
        return r;
    endfunction
    // exact inverse of key_fwd for the same counter value
    function automatic logic [KEY_SIZE-1:0] key_inv(input logic [KEY_SIZE-1:0] k, input logic [4:0] c);
        logic [KEY_SIZE-1:0] r;
        r = k;
        r[19:15] = r[19:15] ^ c;
        r[79:76] = inv_sbox(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction
endpackage

// File: rtl/present_decrypt_if.sv
// present_decrypt_if: request/response bundle for the PRESENT decryptor
// master drives Start, NewKey, orig_key, ciphertext; slave drives plaintext, Busy, Done
interface present_decrypt_if import present_pkg::*; #(
    parameter int size = SIZE,
    parameter int key_size = KEY_SIZE
);
    logic Start;
    logic NewKey;
    logic [key_size-1:0] orig_key;
    logic [size-1:0] ciphertext;
    logic [size-1:0] plaintext;
    logic Busy;
    logic Done;
    modport master (output Start, NewKey, orig_key, ciphertext, input plaintext, Busy, Done);
    modport slave (input Start, NewKey, orig_key, ciphertext, output plaintext, Busy, Done);
endinterface

// File: rtl/present_inv_round.sv
// present_inv_round: one combinational PRESENT decryption round (invP, invS, round-key XOR)
// state_in: round input, round_key: k[79:16], state_out: round result
module present_inv_round import present_pkg::*; #(
    parameter int size = SIZE
) (
    input  logic [size-1:0] state_in,
    input  logic [size-1:0] round_key,
    output logic [size-1:0] state_out
);
    logic [size-1:0] p;
    assign p[size-1] = state_in[size-1];
    for (genvar j = 0; j < size - 1; j++) begin : g_p
        assign p[(4 * j) % (size - 1)] = state_in[j];
    end
    for (genvar n = 0; n < size / 4; n++) begin : g_s
        assign state_out[4*n +: 4] = inv_sbox(p[4*n +: 4]) ^ round_key[4*n +: 4];
    end
endmodule

// File: rtl/present_decrypt.sv
// present_decrypt: iterative PRESENT-80 block decryptor (key expansion, whitening, 31 inverse rounds)
// ports: Clock, Reset (sync, active high), bus (slave: Start/NewKey/orig_key/ciphertext in, plaintext/Busy/Done out)
// PRESENT_KEY_CACHE_EN: caches K32 so a repeat key (NewKey=0) skips key expansion
module present_decrypt import present_pkg::*; #(
    parameter int size = SIZE,
    parameter int key_size = KEY_SIZE,
    parameter int num_rounds = NUM_ROUNDS
) (
    input logic Clock,
    input logic Reset,
    present_decrypt_if.slave bus
);
    localparam logic [4:0] LAST = 5'(num_rounds);
    fsm_e fsm_q, fsm_d;
    logic [4:0] cnt_q, cnt_d;
    logic [size-1:0] st_q, st_d, pt_q, pt_d, round_out;
    logic [key_size-1:0] key_q, key_d, key_nxt;
    logic busy_q, busy_d, done_q, done_d;
    logic cache_hit;
    assign key_nxt = key_fwd(key_q, cnt_q);
`ifdef PRESENT_KEY_CACHE_EN
    logic [key_size-1:0] cache_q, cache_d;
    logic cache_vld_q, cache_vld_d;
    logic key_exp_end;
    assign key_exp_end = (fsm_q == KEYEXP) && (cnt_q == LAST);
    assign cache_d = key_exp_end ? key_nxt : cache_q;
    assign cache_vld_d = cache_vld_q | key_exp_end;
    assign cache_hit = !bus.NewKey && cache_vld_q;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cache_q <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_q <= cache_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`else
    logic unused_newkey;
    assign unused_newkey = bus.NewKey;
    assign cache_hit = 1'b0;
`endif
    present_inv_round #(.size(size)) u_round (
        .state_in (st_q),
        .round_key(key_q[key_size-1 -: size]),
        .state_out(round_out)
    );
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        st_d = st_q;
        key_d = key_q;
        pt_d = pt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (fsm_q)
            IDLE: if (bus.Start) begin
                st_d = bus.ciphertext;
                busy_d = 1'b1;
                cnt_d = 5'd1;
                fsm_d = cache_hit ? WHITEN : KEYEXP;
`ifdef PRESENT_KEY_CACHE_EN
                key_d = cache_hit ? cache_q : bus.orig_key;
`else
                key_d = bus.orig_key;
`endif
            end
            KEYEXP: begin
                key_d = key_nxt;
                cnt_d = cnt_q + 5'd1;
                fsm_d = (cnt_q == LAST) ? WHITEN : KEYEXP;
            end
            WHITEN: begin
                st_d = st_q ^ key_q[key_size-1 -: size];
                key_d = key_inv(key_q, LAST);
                cnt_d = LAST;
                fsm_d = ROUND;
            end
            default: begin
                st_d = round_out;
                cnt_d = cnt_q - 5'd1;
                // the last round needs no further key rollback
                key_d = (cnt_q == 5'd1) ? key_q : key_inv(key_q, cnt_q - 5'd1);
                if (cnt_q == 5'd1) begin
                    pt_d = round_out;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            st_q <= '0;
            key_q <= '0;
            pt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            st_q <= st_d;
            key_q <= key_d;
            pt_q <= pt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign bus.plaintext = pt_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
endmodule
